// File: rtl/matrix_result_tx.sv
// matrix_result_tx: captures one packed DIMxDIM result word over valid/ready
// and streams it out as ASCII digits, spaces and line feeds, one row per line.
// Optional build macro MRTX_HEADER_EN prefixes each frame with "C=\n".
module matrix_result_tx #(
  parameter int ELEM_W = 2,
  parameter int DIM    = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DIM*DIM*ELEM_W-1:0]  in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_byte,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int WORD_W    = DIM*DIM*ELEM_W;
  localparam int MAT_LEN   = DIM*2*DIM;
  localparam int MAX_FRAME = MAT_LEN + 3;
`ifdef MRTX_HEADER_EN
  localparam int HDR_LEN   = 3;
`else
  localparam int HDR_LEN   = 0;
`endif
  localparam int FRAME_LEN = MAT_LEN + HDR_LEN;
  localparam int BEAT_W    = $clog2(MAX_FRAME + 1);
  localparam int ROW_W     = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int POS_W     = $clog2(2*DIM);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(2*DIM - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1
`ifdef MRTX_HEADER_EN
    , S_HDR = 2'd2
`endif
  } state_t;

  state_t              r_state, w_state_nx;
  logic [WORD_W-1:0]   r_shadow;
  logic [BEAT_W-1:0]   r_beat, w_beat_nx;
  logic [ROW_W-1:0]    r_row, w_row_nx;
  logic [POS_W-1:0]    r_pos, w_pos_nx;
  logic                r_in_ready, w_in_ready_nx;
  logic                r_out_valid, w_out_valid_nx;
  logic [7:0]          r_out_byte, w_out_byte_nx;
  logic                r_out_last, w_out_last_nx;
  logic                r_busy, w_busy_nx;
  logic                w_load;
  logic                w_hs;

  // ASCII byte for position pos of row row: digit on even positions,
  // space between digits, line feed closing the row.
  function automatic logic [7:0] f_char(input logic [WORD_W-1:0] word,
                                        input logic [ROW_W-1:0]  row,
                                        input logic [POS_W-1:0]  pos);
    logic [ELEM_W-1:0] elem;
    int                k;
    k    = DIM*int'(row) + int'(pos >> 1);
    elem = word[ELEM_W*k +: ELEM_W];
    if (!pos[0])
      f_char = 8'h30 + {{(8-ELEM_W){1'b0}}, elem};
    else if (pos == POS_LAST)
      f_char = 8'h0A;
    else
      f_char = 8'h20;
  endfunction

`ifdef MRTX_HEADER_EN
  // Header text "C=\n" indexed by beat.
  function automatic logic [7:0] f_hdr(input logic [BEAT_W-1:0] beat);
    case (beat)
      BEAT_W'(0): f_hdr = 8'h43;
      BEAT_W'(1): f_hdr = 8'h3D;
      default:    f_hdr = 8'h0A;
    endcase
  endfunction
`endif

  assign w_hs      = r_out_valid && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

  // Next-state and next-output logic; outputs are computed one beat ahead
  // so every output leaves the block straight from a register.
  always_comb begin
    w_state_nx     = r_state;
    w_beat_nx      = r_beat;
    w_row_nx       = r_row;
    w_pos_nx       = r_pos;
    w_in_ready_nx  = r_in_ready;
    w_out_valid_nx = r_out_valid;
    w_out_byte_nx  = r_out_byte;
    w_out_last_nx  = r_out_last;
    w_busy_nx      = r_busy;
    w_load         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready_nx = 1'b1;
        if (in_valid && r_in_ready) begin
          w_load         = 1'b1;
          w_beat_nx      = '0;
          w_row_nx       = '0;
          w_pos_nx       = '0;
          w_in_ready_nx  = 1'b0;
          w_busy_nx      = 1'b1;
          w_out_valid_nx = 1'b1;
          w_out_last_nx  = 1'b0;
`ifdef MRTX_HEADER_EN
          w_state_nx     = S_HDR;
          w_out_byte_nx  = 8'h43;
`else
          w_state_nx     = S_SEND;
          w_out_byte_nx  = f_char(in_data, '0, '0);
`endif
        end
      end
`ifdef MRTX_HEADER_EN
      S_HDR: begin
        if (w_hs) begin
          w_beat_nx = r_beat + 1'b1;
          if (r_beat == BEAT_W'(HDR_LEN - 1)) begin
            w_state_nx    = S_SEND;
            w_row_nx      = '0;
            w_pos_nx      = '0;
            w_out_byte_nx = f_char(r_shadow, '0, '0);
          end else begin
            w_out_byte_nx = f_hdr(w_beat_nx);
          end
        end
      end
`endif
      S_SEND: begin
        if (w_hs) begin
          if (r_beat == LAST_BEAT) begin
            // Frame done: drop the stream and reopen the input next cycle.
            w_state_nx     = S_IDLE;
            w_beat_nx      = '0;
            w_row_nx       = '0;
            w_pos_nx       = '0;
            w_out_valid_nx = 1'b0;
            w_out_last_nx  = 1'b0;
            w_out_byte_nx  = 8'h00;
            w_busy_nx      = 1'b0;
            w_in_ready_nx  = 1'b1;
          end else begin
            w_beat_nx = r_beat + 1'b1;
            if (r_pos == POS_LAST) begin
              w_pos_nx = '0;
              w_row_nx = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
              w_pos_nx = r_pos + 1'b1;
            end
            w_out_byte_nx = f_char(r_shadow, w_row_nx, w_pos_nx);
            w_out_last_nx = (w_beat_nx == LAST_BEAT);
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_row       <= '0;
      r_pos       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_beat      <= w_beat_nx;
      r_row       <= w_row_nx;
      r_pos       <= w_pos_nx;
      r_in_ready  <= w_in_ready_nx;
      r_out_valid <= w_out_valid_nx;
      r_out_byte  <= w_out_byte_nx;
      r_out_last  <= w_out_last_nx;
      r_busy      <= w_busy_nx;
    end
  end

  // Shadow copy of the captured word; the only data source during a frame.
  always_ff @(posedge clk) begin
    if (w_load) r_shadow <= in_data;
  end

endmodule

// File: tb/tb_matrix_result_tx.sv
// Bench for matrix_result_tx: a queue-based reference model of the frame
// text, checked against the DUT every cycle, plus literal spot checks.
module tb_matrix_result_tx;
  localparam int EW  = 2;
  localparam int DIM = 3;
  localparam int W   = DIM*DIM*EW;
`ifdef MRTX_HEADER_EN
  localparam int HOFF = 3;
`else
  localparam int HOFF = 0;
`endif
  localparam int FLEN = DIM*2*DIM + HOFF;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_last, out_ready, busy;
  logic [W-1:0] in_data;
  logic [7:0]   out_byte;

  matrix_result_tx #(.ELEM_W(EW), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_byte(out_byte),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_cap = 0;
  int last_pop = -100;
  int ormode = 0;
  bit b2b = 0;
  bit armed;
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] lit[18] = '{8'h32, 8'h20, 8'h32, 8'h20, 8'h30, 8'h0A,
                          8'h30, 8'h20, 8'h31, 8'h20, 8'h31, 8'h0A,
                          8'h32, 8'h20, 8'h33, 8'h20, 8'h31, 8'h0A};

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: byte i of the frame for word w, from the text layout rules.
  function automatic logic [7:0] mdl_byte(input logic [W-1:0] w, input int i);
    int j, r, p;
    logic [W-1:0] e;
    j = i;
`ifdef MRTX_HEADER_EN
    if (i == 0) return 8'h43;
    if (i == 1) return 8'h3D;
    if (i == 2) return 8'h0A;
    j = i - 3;
`endif
    r = j / (2*DIM);
    p = j % (2*DIM);
    if (p % 2 == 0) begin
      e = (w >> (EW*(DIM*r + p/2))) & W'((1 << EW) - 1);
      return 8'h30 + 8'(e);
    end
    if (p == 2*DIM-1) return 8'h0A;
    return 8'h20;
  endfunction

  // in_ready is expected from the first edge after reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // out_ready patterns: always 1, 1-0-0-1 repeating, or random.
  initial begin
    int k;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ormode)
        0: out_ready = 1'b1;
        1: begin out_ready = (k % 4 == 0) || (k % 4 == 3); k++; end
        default: out_ready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Compare process: every cycle the DUT must match the model queue.
  always @(negedge clk) begin
    bit was_empty;
    cyc++;
    if (!rst_n) q.delete();
    was_empty = (q.size() == 0);
    chk("out_valid", out_valid, !was_empty);
    chk("busy", busy, !was_empty);
    chk("in_ready", in_ready, armed && was_empty);
    if (!was_empty) begin
      chk("out_byte", out_byte, q[0]);
      chk("out_last", out_last, q.size() == 1);
      if (out_ready) begin
        got.push_back(q[0]);
        void'(q.pop_front());
        last_pop = cyc;
      end
    end else begin
      chk("out_last_idle", out_last, 0);
    end
    if (rst_n && armed && was_empty && in_valid) begin
      for (int i = 0; i < FLEN; i++) q.push_back(mdl_byte(in_data, i));
      n_cap++;
      if (b2b) chk("b2b_gap", cyc - last_pop, 1);
    end
  end

  task automatic wait_cap(input int c0);
    int n;
    n = 0;
    while (n_cap == c0 && n < 200) begin @(posedge clk); #1; n++; end
    if (n_cap == c0) chk("capture_timeout", 0, 1);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 600) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) chk("frame_timeout", q.size(), 0);
  endtask

  task automatic do_reset();
    in_valid = 0;
    in_data  = '0;
    rst_n    = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    int base, c0, n;
    rst_n = 0;
    in_valid = 0;
    in_data = '0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_busy", busy, 0);
    do_reset();

    // Pin the model against the hand-written frame text.
    for (int i = 0; i < 18; i++) chk("model_pin", mdl_byte(18'h1E50A, HOFF + i), lit[i]);

    // Frame with out_ready held high, then with stalls.
    for (int m = 0; m < 2; m++) begin
      ormode = m;
      got.delete();
      c0 = n_cap;
      in_data = 18'h1E50A;
      in_valid = 1;
      wait_cap(c0);
      in_valid = 0;
      wait_empty();
      @(posedge clk); #1;
      chk("frame_len", got.size(), FLEN);
      if (got.size() == FLEN)
        for (int i = 0; i < 18; i++) chk("frame_lit", got[HOFF + i], lit[i]);
`ifdef MRTX_HEADER_EN
      if (got.size() == FLEN) begin
        chk("hdr0", got[0], 8'h43);
        chk("hdr1", got[1], 8'h3D);
        chk("hdr2", got[2], 8'h0A);
      end
`endif
    end

    // Input changes mid-frame with in_valid held: shadow data must be used.
    ormode = 0;
    got.delete();
    c0 = n_cap;
    in_data = 18'h3FFFF;
    in_valid = 1;
    wait_cap(c0);
    repeat (4) @(posedge clk);
    #1 in_data = '0;
    wait_cap(c0 + 1);
    in_valid = 0;
    wait_empty();
    if (got.size() == 2*FLEN) begin
      chk("all_three", got[HOFF], 8'h33);
      chk("all_three_last_digit", got[HOFF + 16], 8'h33);
      chk("second_zero", got[FLEN + HOFF], 8'h30);
    end else chk("two_frames_len", got.size(), 2*FLEN);

    // Asynchronous reset after byte 7 is accepted.
    got.delete();
    c0 = n_cap;
    in_data = 18'h1E50A;
    in_valid = 1;
    wait_cap(c0);
    in_valid = 0;
    n = 0;
    while (got.size() < 7 && n < 100) begin @(posedge clk); #1; n++; end
    chk("seven_bytes", got.size(), 7);
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_byte", out_byte, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    got.delete();
    c0 = n_cap;
    in_data = 18'h00006;
    in_valid = 1;
    wait_cap(c0);
    in_valid = 0;
    wait_empty();
    if (got.size() > HOFF) chk("restart_elem00", got[HOFF], 8'h32);
    else chk("restart_len", got.size(), FLEN);

    // Back-to-back captures with in_valid held high.
    c0 = n_cap;
    in_data = 18'h2AAAA;
    in_valid = 1;
    wait_cap(c0);
    b2b = 1;
    in_data = 18'h15555;
    wait_cap(c0 + 1);
    b2b = 0;
    in_valid = 0;
    wait_empty();

    // Randomized frames with random backpressure.
    ormode = 2;
    for (int f = 0; f < 25; f++) begin
      c0 = n_cap;
      in_data = W'($urandom);
      in_valid = 1;
      wait_cap(c0);
      in_valid = $urandom_range(0, 1);
      if (in_valid) in_data = W'($urandom);
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
      in_valid = 0;
      wait_empty();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required below 400000", $time);
    $fatal(1);
  end
endmodule
